// File: rtl/conv3x3_mac.sv
// 3x3 convolution window MAC: streams ELEMS data/weight halfword pairs from two RAMs
// and produces one signed dot product. Define CONV3X3_RELU_EN to clamp negative results to 0.
module conv3x3_mac #(
    parameter int ELEMS = 9,
    parameter int ACC_W = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             d_rd_en,
    output logic [3:0]       d_rd_addr,
    input  logic [15:0]      d_rd_data,
    output logic             w_rd_en,
    output logic [3:0]       w_rd_addr,
    input  logic [15:0]      w_rd_data,
    output logic             res_vld,
    output logic [ACC_W-1:0] res_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_ADDR = 4'(ELEMS - 1);

    state_t                   state_r;
    logic [3:0]               addr_r;
    logic                     rd_en_r;
    logic                     pend_r;
    logic                     busy_r;
    logic                     res_vld_r;
    logic [ACC_W-1:0]         res_data_r;
    logic                     v1_r;
    logic                     v2_r;
    logic                     v3_r;
    logic signed [15:0]       data_r;
    logic signed [15:0]       wgt_r;
    logic signed [31:0]       prod_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [ACC_W-1:0]  final_s;
    logic                     accept_s;

    // Accumulate-path arithmetic and the result presented when the window completes
    always_comb begin
        prod_ext_s = ACC_W'(prod_r);
        sum_s      = acc_r + prod_ext_s;
        accept_s   = (state_r == IDLE) && (start || pend_r);
`ifdef CONV3X3_RELU_EN
        if (sum_s[ACC_W-1]) begin
            final_s = {ACC_W{1'b0}};
        end else begin
            final_s = sum_s;
        end
`else
        final_s = sum_s;
`endif
    end

    // Read-data register, product register and accumulator, tagged by a valid pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r   <= 1'b0;
            v2_r   <= 1'b0;
            v3_r   <= 1'b0;
            data_r <= 16'sd0;
            wgt_r  <= 16'sd0;
            prod_r <= 32'sd0;
            acc_r  <= {ACC_W{1'b0}};
        end else begin
            v1_r <= rd_en_r;
            v2_r <= v1_r;
            v3_r <= v2_r;
            if (v1_r) begin
                data_r <= d_rd_data;
                wgt_r  <= w_rd_data;
            end else begin
                data_r <= data_r;
                wgt_r  <= wgt_r;
            end
            if (v2_r) begin
                prod_r <= data_r * wgt_r;
            end else begin
                prod_r <= 32'sd0;
            end
            if (accept_s) begin
                acc_r <= {ACC_W{1'b0}};
            end else if (v3_r) begin
                acc_r <= sum_s;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    // Window sequencer; a start seen in DONE is held and taken up on the next IDLE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            addr_r     <= 4'd0;
            rd_en_r    <= 1'b0;
            pend_r     <= 1'b0;
            busy_r     <= 1'b0;
            res_vld_r  <= 1'b0;
            res_data_r <= {ACC_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    res_vld_r  <= 1'b0;
                    res_data_r <= {ACC_W{1'b0}};
                    if (start || pend_r) begin
                        state_r <= READ;
                        rd_en_r <= 1'b1;
                        addr_r  <= 4'd0;
                        busy_r  <= 1'b1;
                        pend_r  <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    if (addr_r == LAST_ADDR) begin
                        rd_en_r <= 1'b0;
                        addr_r  <= 4'd0;
                        state_r <= DRAIN;
                    end else begin
                        addr_r  <= addr_r + 4'd1;
                    end
                end
                DRAIN: begin
                    // last product is in flight when stage 3 is valid but stage 2 is empty
                    if (v3_r && !v2_r) begin
                        state_r    <= DONE;
                        busy_r     <= 1'b0;
                        res_vld_r  <= 1'b1;
                        res_data_r <= final_s;
                    end else begin
                        state_r    <= DRAIN;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    res_vld_r  <= 1'b0;
                    res_data_r <= {ACC_W{1'b0}};
                    if (start) begin
                        pend_r <= 1'b1;
                        busy_r <= 1'b1;
                    end else begin
                        pend_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    rd_en_r    <= 1'b0;
                    addr_r     <= 4'd0;
                    busy_r     <= 1'b0;
                    res_vld_r  <= 1'b0;
                    res_data_r <= {ACC_W{1'b0}};
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign d_rd_en   = rd_en_r;
    assign d_rd_addr = addr_r;
    assign w_rd_en   = rd_en_r;
    assign w_rd_addr = addr_r;
    assign res_vld   = res_vld_r;
    assign res_data  = res_data_r;

endmodule

// File: doc/conv3x3_mac.md
CONV3X3_MAC -- requirements
Module: conv3x3_mac

Interface
REQ-001 SHALL have parameter ELEMS, default 9, meaning the number of 16-bit halfwords read per window (RAM addresses 0..ELEMS-1, ELEMS <= 16).
REQ-002 SHALL have parameter ACC_W, default 36, meaning the accumulator and result width in bits (ACC_W >= 32).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle request to compute one window.
REQ-007 SHALL have port busy  out  1  high from the cycle after an accepted start until res_vld is asserted.
REQ-008 SHALL have port d_rd_en  out  1  data-RAM read enable.
REQ-009 SHALL have port d_rd_addr  out  4  data-RAM halfword address.
REQ-010 SHALL have port d_rd_data  in  16  data-RAM read data, signed, valid one cycle after d_rd_en.
REQ-011 SHALL have port w_rd_en  out  1  weight-RAM read enable, identical timing to d_rd_en.
REQ-012 SHALL have port w_rd_addr  out  4  weight-RAM halfword address, equal to d_rd_addr.
REQ-013 SHALL have port w_rd_data  in  16  weight-RAM read data, signed, valid one cycle after w_rd_en.
REQ-014 SHALL have port res_vld  out  1  single-cycle result strobe.
REQ-015 SHALL have port res_data  out  ACC_W  signed dot-product result, valid only while res_vld is high.

Function
REQ-016 SHALL implement FSM states IDLE, READ, DRAIN, DONE; IDLE->READ on start, READ->DRAIN after address ELEMS-1 is issued, DRAIN->DONE when the last product has been accumulated, DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL ignore start in any state other than IDLE, with no effect on the running computation.
REQ-018 SHALL clear the accumulator to 0 in the cycle start is accepted.
REQ-019 SHALL, with start high in cycle 0, assert d_rd_en/w_rd_en in cycles 1..ELEMS with address k in cycle k+1, and hold both enables low and addresses 0 at all other times.
REQ-020 SHALL register the returned data and weight pair, form the full signed 32-bit product in the following cycle into a product register, and add it sign-extended to ACC_W into the accumulator in the cycle after that.
REQ-021 SHALL assert res_vld for exactly one cycle, in cycle ELEMS+4 after the start cycle (cycle 13 for ELEMS=9), with res_data driven to the final accumulator value.
REQ-022 SHALL drive res_data to 0 whenever res_vld is low.
REQ-023 SHALL wrap accumulation modulo 2^ACC_W without saturation.
REQ-024 SHALL accept a new start in the cycle res_vld is high (FSM returns to IDLE that cycle), giving back-to-back windows every ELEMS+5 cycles.

Reset
REQ-025 SHALL, on rst high at a clock edge, return the FSM to IDLE and clear busy, d_rd_en, w_rd_en, d_rd_addr, w_rd_addr, res_vld, res_data, the product pipeline, and the accumulator to 0.
REQ-026 SHALL, on rst asserted mid-operation, abandon the window with no res_vld produced for it, and rst SHALL take priority over a coincident start.

Configuration
REQ-027 SHALL, when macro CONV3X3_RELU_EN is defined, output 0 in place of any negative final accumulator value, with latency unchanged.
REQ-028 SHALL, when CONV3X3_RELU_EN is undefined, output the signed accumulator value unmodified.

Verification
REQ-029 SHALL cover data all 1 and weights all 2 with start pulsed -> res_vld in cycle 13, res_data=18, 9 reads at addresses 0..8.
REQ-030 SHALL cover data all -3 and weights all 4 -> res_data=-108 without CONV3X3_RELU_EN and 0 with it.
REQ-031 SHALL cover data all 0x7FFF and weights all 0x7FFF -> res_data=9*0x3FFF0001=0x23FF70009 with no overflow at ACC_W=36.
REQ-032 SHALL cover start re-pulsed in cycles 3 and 8 -> no effect, exactly one res_vld, and a start in the res_vld cycle accepted with its result in cycle 27.
REQ-033 SHALL cover rst asserted in cycle 6 -> all outputs 0 in the next cycle, no res_vld, and the following start producing a correct fresh result.
